// File: rtl/memory_arbiter_pkg.sv
// Shared types and encodings for the round-robin memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/memory_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         req_i,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr_i,
  output logic [NUM_PORTS-1:0]         gnt_o,
  output logic [$clog2(NUM_PORTS)-1:0] idx_o,
  output logic                         any_o
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  logic [IdxW-1:0] cand;

  // Walk the ports starting at ptr; the first requester seen wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % NUM_PORTS);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_PORTS requesters,
// one outstanding transaction at a time, with optional response timeout.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  localparam int unsigned MASK_W        = DATA_W / 8,
  localparam int unsigned IDX_W         = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        enable_i,
  input  logic [NUM_PORTS-1:0]        command_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] address_i,
  input  logic [NUM_PORTS*DATA_W-1:0] write_data_i,
  input  logic [NUM_PORTS*MASK_W-1:0] write_mask_i,
  output logic [DATA_W-1:0]           read_data_o,
  output logic [NUM_PORTS-1:0]        valid_o,
  output logic                        enable,
  output logic                        command,
  output logic [ADDR_W-1:0]           address,
  output logic [DATA_W-1:0]           write_data,
  output logic [MASK_W-1:0]           write_mask,
  input  logic [DATA_W-1:0]           read_data,
  input  logic                        valid,
  output logic [IDX_W-1:0]            owner_o,
  output logic                        busy_o,
  output logic                        timeout_o
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, owner_q, owner_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               en_q, en_d, cmd_q, cmd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [MASK_W-1:0]  wmask_q, wmask_d;

  logic [NUM_PORTS-1:0] gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic                 to_hit;

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr (
    .req_i(enable_i),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gnt_idx),
    .any_o(gnt_any)
  );

  // Counter reached its last allowed cycle; only meaningful when the timeout is enabled.
  assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

  // State and request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      cmd_q   <= CMD_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  // Next state: grant and capture in IDLE, hold and wait for completion in BUSY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d = BUSY;
          owner_d = gnt_idx;
          cnt_d   = '0;
          en_d    = 1'b1;
          for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) begin
              cmd_d   = command_i[p];
              addr_d  = address_i[p*ADDR_W +: ADDR_W];
              wdata_d = write_data_i[p*DATA_W +: DATA_W];
              wmask_d = write_mask_i[p*MASK_W +: MASK_W];
            end
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 32'd1;
        if (valid || to_hit) begin
          state_d = IDLE;
          en_d    = 1'b0;
          ptr_d   = (owner_q == IDX_W'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: completion strobe is combinational on the memory response.
  always_comb begin
    valid_o   = '0;
    timeout_o = 1'b0;
    busy_o    = (state_q == BUSY);
    if (state_q == BUSY && (valid || to_hit)) begin
      valid_o[owner_q] = 1'b1;
      timeout_o        = to_hit && !valid;
    end
  end

  assign read_data_o = read_data;
  assign enable      = en_q;
  assign command     = cmd_q;
  assign address     = addr_q;
  assign write_data  = wdata_q;
  assign write_mask  = wmask_q;
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: scoreboard of expected completions plus
// cycle-accurate checks on the memory-side request and arbiter status.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [NP-1:0]     enable_i, command_i;
  logic [NP*AW-1:0]  address_i;
  logic [NP*DW-1:0]  write_data_i;
  logic [NP*MW-1:0]  write_mask_i;
  logic [DW-1:0]     read_data_o, read_data;
  logic [NP-1:0]     valid_o;
  logic              enable, command;
  logic [AW-1:0]     address;
  logic [DW-1:0]     write_data;
  logic [MW-1:0]     write_mask;
  logic              valid, valid_man, mem_auto;
  logic [1:0]        owner_o;
  logic              busy_o, timeout_o;

  // Zero-wait memory in auto mode answers in the same cycle it sees enable.
  assign valid = mem_auto ? enable : valid_man;

  memory_arbiter #(
    .NUM_PORTS(NP),
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable_i(enable_i),
    .command_i(command_i),
    .address_i(address_i),
    .write_data_i(write_data_i),
    .write_mask_i(write_mask_i),
    .read_data_o(read_data_o),
    .valid_o(valid_o),
    .enable(enable),
    .command(command),
    .address(address),
    .write_data(write_data),
    .write_mask(write_mask),
    .read_data(read_data),
    .valid(valid),
    .owner_o(owner_o),
    .busy_o(busy_o),
    .timeout_o(timeout_o)
  );

  typedef struct {
    logic [NP-1:0] vo;
    logic          to;
    logic [DW-1:0] rd;
    logic [AW-1:0] addr;
    logic          cmd;
    logic [DW-1:0] wd;
    logic [MW-1:0] wm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [NP-1:0] vo, input logic to, input logic [DW-1:0] rd,
                      input logic [AW-1:0] addr, input logic cmd, input logic [DW-1:0] wd,
                      input logic [MW-1:0] wm);
    exp_t x;
    x.vo = vo; x.to = to; x.rd = rd; x.addr = addr; x.cmd = cmd; x.wd = wd; x.wm = wm;
    sb.push_back(x);
  endtask

  task automatic set_port(input int p, input logic cmd, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    command_i[p]                = cmd;
    address_i[p*AW +: AW]       = addr;
    write_data_i[p*DW +: DW]    = wd;
    write_mask_i[p*MW +: MW]    = wm;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completion strobe must match the oldest expected transaction.
  always @(negedge clk) begin
    if (valid_o !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_o", 64'(valid_o), 64'(0));
      end else begin
        e = sb.pop_front();
        check("sb_valid_o", 64'(valid_o), 64'(e.vo));
        check("sb_timeout_o", 64'(timeout_o), 64'(e.to));
        check("sb_read_data_o", 64'(read_data_o), 64'(e.rd));
        check("sb_address", 64'(address), 64'(e.addr));
        check("sb_command", 64'(command), 64'(e.cmd));
        check("sb_write_data", 64'(write_data), 64'(e.wd));
        check("sb_write_mask", 64'(write_mask), 64'(e.wm));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  int           ord[5] = '{0, 1, 2, 3, 0};
  logic [AW-1:0] a_of;
  logic [DW-1:0] w_of;
  logic [MW-1:0] m_of;

  initial begin
    reset_n = 1'b0; enable_i = '0; command_i = '0; address_i = '0;
    write_data_i = '0; write_mask_i = '0; read_data = '0; valid_man = 1'b0; mem_auto = 1'b0;
    repeat (2) cycle();
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_enable", 64'(enable), 64'(0));
    check("rst_owner", 64'(owner_o), 64'(0));
    check("rst_valid_o", 64'(valid_o), 64'(0));
    check("rst_timeout", 64'(timeout_o), 64'(0));
    check("rst_request", 64'({command, address, write_mask}), 64'(0));
    check("rst_wdata", 64'(write_data), 64'(0));
    reset_n = 1'b1;

    // Single read on port 2, memory answers in the third enable cycle.
    set_port(2, CMD_READ, 32'h100, 32'h0, 4'h0);
    enable_i = 4'b0100;
    push(4'b0100, 1'b0, 32'hDEADBEEF, 32'h100, CMD_READ, 32'h0, 4'h0);
    cycle();
    check("t1_owner", 64'(owner_o), 64'(2));
    check("t1_busy", 64'(busy_o), 64'(1));
    check("t1_enable_c1", 64'(enable), 64'(1));
    check("t1_address", 64'(address), 64'(32'h100));
    cycle();
    check("t1_enable_c2", 64'(enable), 64'(1));
    cycle();
    check("t1_enable_c3", 64'(enable), 64'(1));
    read_data = 32'hDEADBEEF;
    valid_man = 1'b1;
    #1;
    check("t1_valid_o", 64'(valid_o), 64'(4'b0100));
    check("t1_read_data_o", 64'(read_data_o), 64'(32'hDEADBEEF));
    cycle();
    valid_man = 1'b0;
    enable_i  = '0;
    check("t1_enable_off", 64'(enable), 64'(0));
    check("t1_idle", 64'(busy_o), 64'(0));

    // Pointer must now sit at 3: ports 0 and 3 compete, 3 wins, then 0.
    set_port(0, CMD_WRITE, 32'h40, 32'hAAAA5555, 4'hF);
    set_port(3, CMD_READ, 32'h300C, 32'h0, 4'h0);
    enable_i = 4'b1001;
    push(4'b1000, 1'b0, 32'h11111111, 32'h300C, CMD_READ, 32'h0, 4'h0);
    cycle();
    check("ptr_owner3", 64'(owner_o), 64'(3));
    read_data = 32'h11111111;
    valid_man = 1'b1;
    cycle();
    valid_man = 1'b0;
    enable_i  = 4'b0001;
    push(4'b0001, 1'b0, 32'h22222222, 32'h40, CMD_WRITE, 32'hAAAA5555, 4'hF);
    cycle();
    check("ptr_owner0", 64'(owner_o), 64'(0));
    read_data = 32'h22222222;
    valid_man = 1'b1;
    cycle();
    valid_man = 1'b0;
    enable_i  = '0;

    // All four ports requesting from reset, zero-wait memory.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int p = 0; p < NP; p++) begin
      set_port(p, p[0], 32'h1000 + 32'(4 * p), 32'h01010101 * 32'(p + 1), MW'(1 << p));
    end
    for (int k = 0; k < 5; k++) begin
      a_of = 32'h1000 + 32'(4 * ord[k]);
      w_of = 32'h01010101 * 32'(ord[k] + 1);
      m_of = MW'(1 << ord[k]);
      push(NP'(1 << ord[k]), 1'b0, 32'hCAFEF00D, a_of, ord[k][0], w_of, m_of);
    end
    read_data = 32'hCAFEF00D;
    mem_auto  = 1'b1;
    enable_i  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rr_owner", 64'(owner_o), 64'(ord[k]));
      check("rr_busy", 64'(busy_o), 64'(1));
      if (k == 4) enable_i = '0;
      cycle();
      check("rr_idle", 64'(busy_o), 64'(0));
    end
    mem_auto = 1'b0;

    // Write on port 1; port 0 requests mid-flight and fields get disturbed.
    set_port(1, CMD_WRITE, 32'h2000, 32'h12345678, 4'hA);
    set_port(0, CMD_READ, 32'h500, 32'h0, 4'h0);
    enable_i = 4'b0010;
    push(4'b0010, 1'b0, 32'h33333333, 32'h2000, CMD_WRITE, 32'h12345678, 4'hA);
    cycle();
    check("wr_owner", 64'(owner_o), 64'(1));
    enable_i = 4'b0011;
    set_port(1, CMD_READ, 32'hBAD0, 32'h0, 4'h0);
    cycle();
    check("wr_hold_addr", 64'(address), 64'(32'h2000));
    check("wr_hold_wdata", 64'(write_data), 64'(32'h12345678));
    check("wr_hold_mask", 64'(write_mask), 64'(4'hA));
    check("wr_hold_cmd", 64'(command), 64'(1));
    check("wr_hold_owner", 64'(owner_o), 64'(1));
    read_data = 32'h33333333;
    valid_man = 1'b1;
    cycle();
    valid_man = 1'b0;
    enable_i  = 4'b0001;
    push(4'b0001, 1'b0, 32'h44444444, 32'h500, CMD_READ, 32'h0, 4'h0);
    cycle();
    check("wr_next_owner", 64'(owner_o), 64'(0));
    check("wr_next_addr", 64'(address), 64'(32'h500));
    read_data = 32'h44444444;
    valid_man = 1'b1;
    cycle();
    valid_man = 1'b0;
    enable_i  = '0;

    // Memory never answers: timeout fires in the 8th BUSY cycle.
    set_port(2, CMD_READ, 32'h300, 32'h0, 4'h0);
    enable_i  = 4'b0100;
    read_data = 32'h55AA55AA;
    push(4'b0100, 1'b1, 32'h55AA55AA, 32'h300, CMD_READ, 32'h0, 4'h0);
    cycle();
    for (int c = 1; c < 8; c++) begin
      check("to_quiet", 64'({timeout_o, valid_o}), 64'(0));
      cycle();
    end
    check("to_fire", 64'({timeout_o, valid_o}), 64'({1'b1, 4'b0100}));
    enable_i = '0;
    cycle();
    check("to_idle", 64'({busy_o, timeout_o, enable}), 64'(0));

    // Response on the expiry cycle counts as normal completion.
    set_port(3, CMD_READ, 32'h3FC, 32'h0, 4'h0);
    enable_i  = 4'b1000;
    read_data = 32'h66666666;
    push(4'b1000, 1'b0, 32'h66666666, 32'h3FC, CMD_READ, 32'h0, 4'h0);
    cycle();
    repeat (7) cycle();
    valid_man = 1'b1;
    #1;
    check("coincide_timeout", 64'(timeout_o), 64'(0));
    check("coincide_valid_o", 64'(valid_o), 64'(4'b1000));
    cycle();
    valid_man = 1'b0;
    enable_i  = '0;
    check("coincide_idle", 64'(busy_o), 64'(0));

    // Spurious memory valid while idle.
    valid_man = 1'b1;
    read_data = 32'h77777777;
    for (int c = 0; c < 2; c++) begin
      cycle();
      check("spur_valid_o", 64'(valid_o), 64'(0));
      check("spur_busy", 64'(busy_o), 64'(0));
    end
    valid_man = 1'b0;

    // Reset in the second BUSY cycle drops the transaction.
    set_port(1, CMD_WRITE, 32'h1234, 32'h0BADF00D, 4'h3);
    enable_i = 4'b0010;
    cycle();
    check("rstmid_busy", 64'(busy_o), 64'(1));
    cycle();
    valid_man = 1'b1;
    reset_n   = 1'b0;
    #1;
    check("rstmid_enable", 64'(enable), 64'(0));
    check("rstmid_valid_o", 64'(valid_o), 64'(0));
    check("rstmid_addr", 64'(address), 64'(0));
    enable_i  = '0;
    valid_man = 1'b0;
    cycle();
    reset_n = 1'b1;
    repeat (2) cycle();
    check("rstmid_after", 64'({busy_o, owner_o}), 64'(0));

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
